// File: rtl/multdiv_iter_if.sv
// ---------------------------------------------------------------------------
// multdiv_iter_if
// Operand, control and result bundle between the execute stage and the
// iterative multiply/divide unit.
//   master : execute-stage control (drives operands, start pulses, flush)
//   slave  : multdiv_iter (drives result, exception, ready, tag, busy)
// Signals:
//   data_operandA/B  signed operands, sampled with a start pulse
//   ctrl_MULT/DIV    one-cycle start pulses (MULT wins if both high)
//   tag_in           destination tag captured with start
//   flush            cancel the in-flight operation
//   data_result      signed result
//   data_exception   overflow / divide-by-zero, valid with ready
//   data_resultRDY   one-cycle completion pulse
//   tag_out          tag of the completed operation
//   busy             operation in flight
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface multdiv_iter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, tag_in, flush,
    input  data_result, data_exception, data_resultRDY, tag_out, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, tag_in, flush,
    output data_result, data_exception, data_resultRDY, tag_out, busy
  );
endinterface

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ---------------------------------------------------------------------------
// multdiv_iter
// Iterative signed multiply / divide unit. One iteration per clock for WIDTH
// clocks, result presented WIDTH+1 edges after the start edge together with
// a one-cycle ready pulse. A new start restarts the unit in any state; flush
// cancels the in-flight operation without a ready pulse.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    multdiv_iter_if.slave (operands, controls, results, busy)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  wire logic     clock,
  input  wire logic     reset,
  multdiv_iter_if.slave bus
);

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_cnt;
  logic                 r_neg;      // result sign = signA ^ signB
  logic                 r_dz;       // divide by zero
  logic                 r_ovf;      // MIN / -1
  logic [2*WIDTH-1:0]   r_acc;      // product magnitude accumulator
  logic [2*WIDTH-1:0]   r_mcand;    // multiplicand magnitude, shifted left
  logic [WIDTH-1:0]     r_mplier;   // multiplier magnitude, shifted right
  logic [WIDTH:0]       r_rem;      // partial remainder
  logic [WIDTH-1:0]     r_quo;      // dividend shifting out / quotient in
  logic [WIDTH-1:0]     r_dsor;     // divisor magnitude
  logic [TAG_W-1:0]     r_tag;
  logic [WIDTH-1:0]     r_result;
  logic                 r_exc;
  logic [TAG_W-1:0]     r_tag_out;

  logic                 w_start;
  logic                 w_last;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_phi;
  logic                 w_mexc;
  logic [WIDTH-1:0]     w_quo_s;

  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign w_last  = (r_cnt == C_LAST);

  // Magnitudes; MIN maps onto itself, which is the correct unsigned 2^(W-1).
  assign w_magA = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign w_magB = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  // Restoring division step: MSB of the difference is set exactly when the
  // shifted remainder is smaller than the divisor.
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dsor};

  // Sign-corrected product; it fits in WIDTH bits iff the top WIDTH+1 bits agree.
  assign w_prod  = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_phi   = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mexc  = ~((&w_phi) | ~(|w_phi));
  assign w_quo_s = r_neg ? (~r_quo + 1'b1) : r_quo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = bus.ctrl_MULT ? S_MULT : S_DIV;
    end else if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_MULT:  w_next = w_last ? S_DONE : S_MULT;
        S_DIV:   w_next = w_last ? S_DONE : S_DIV;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dsor    <= '0;
      r_tag     <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_tag_out <= '0;
    end else if (w_start) begin
      r_cnt    <= '0;
      r_neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      r_dz     <= (bus.data_operandB == '0);
      r_ovf    <= (bus.data_operandA == C_MIN) && (bus.data_operandB == '1);
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, w_magA};
      r_mplier <= w_magB;
      r_rem    <= '0;
      r_quo    <= w_magA;
      r_dsor   <= w_magB;
      r_tag    <= bus.tag_in;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if ((r_state == S_MULT) || (r_state == S_DIV)) begin
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == S_MULT) begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        end else begin
          if (w_diff[WIDTH]) begin
            r_rem <= w_rem_sh;
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end else begin
            r_rem <= w_diff;
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end
        end
      end else begin
        r_cnt     <= '0;
        r_tag_out <= r_tag;
        if (r_state == S_MULT) begin
          r_result <= w_prod[WIDTH-1:0];
          r_exc    <= w_mexc;
        end else begin
          r_result <= r_dz ? '0 : w_quo_s;
          r_exc    <= r_dz | r_ovf;
        end
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.tag_out        = r_tag_out;
  assign bus.busy           = (r_state == S_MULT) || (r_state == S_DIV);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// ---------------------------------------------------------------------------
// tb_multdiv_iter
// Directed self-checking bench for multdiv_iter at WIDTH=32/TAG_W=5 and
// WIDTH=8/TAG_W=3. Expected values are hand-computed constants.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multdiv_iter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  multdiv_iter_if #(.WIDTH(32), .TAG_W(5)) if32 ();
  multdiv_iter_if #(.WIDTH(8),  .TAG_W(3)) if8 ();

  multdiv_iter #(.WIDTH(32), .TAG_W(5)) u_dut32 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if32.slave)
  );

  multdiv_iter #(.WIDTH(8), .TAG_W(3)) u_dut8 (
    .clock (clk),
    .reset (rst_n),
    .bus   (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle ready/busy check plus result check at the completion edge.
  task automatic run32(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] er, input logic ee, input string nm);
    if32.data_operandA = a;
    if32.data_operandB = b;
    if32.tag_in        = tag;
    if32.ctrl_MULT     = m;
    if32.ctrl_DIV      = d;
    @(posedge clk); #1;
    if32.ctrl_MULT     = 1'b0;
    if32.ctrl_DIV      = 1'b0;
    if32.data_operandA = ~a;
    if32.data_operandB = ~b;
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if32.data_resultRDY !== (n == 33)) begin
        n_fail++;
        $display("FAIL %s rdy edge %0d: got %b want %b", nm, n, if32.data_resultRDY, (n == 33));
      end
      n_checks++;
      if (if32.busy !== (n < 33)) begin
        n_fail++;
        $display("FAIL %s busy edge %0d: got %b want %b", nm, n, if32.busy, (n < 33));
      end
      if (n == 33) begin
        n_checks++;
        if (if32.data_result !== er || if32.data_exception !== ee || if32.tag_out !== tag) begin
          n_fail++;
          $display("FAIL %s result: got %h/%b/%0d want %h/%b/%0d", nm, if32.data_result,
                   if32.data_exception, if32.tag_out, er, ee, tag);
        end
      end
    end
  endtask

  task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] tag, input logic [7:0] er, input logic ee,
                      input string nm);
    if8.data_operandA = a;
    if8.data_operandB = b;
    if8.tag_in        = tag;
    if8.ctrl_MULT     = m;
    if8.ctrl_DIV      = ~m;
    @(posedge clk); #1;
    if8.ctrl_MULT     = 1'b0;
    if8.ctrl_DIV      = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if8.data_resultRDY !== (n == 9) || if8.busy !== (n < 9)) begin
        n_fail++;
        $display("FAIL %s rdy/busy edge %0d: got %b/%b want %b/%b", nm, n,
                 if8.data_resultRDY, if8.busy, (n == 9), (n < 9));
      end
      if (n == 9) begin
        n_checks++;
        if (if8.data_result !== er || if8.data_exception !== ee || if8.tag_out !== tag) begin
          n_fail++;
          $display("FAIL %s result: got %h/%b/%0d want %h/%b/%0d", nm, if8.data_result,
                   if8.data_exception, if8.tag_out, er, ee, tag);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if32.data_operandA = '0; if32.data_operandB = '0; if32.tag_in = '0;
    if32.ctrl_MULT = 1'b0; if32.ctrl_DIV = 1'b0; if32.flush = 1'b0;
    if8.data_operandA = '0; if8.data_operandB = '0; if8.tag_in = '0;
    if8.ctrl_MULT = 1'b0; if8.ctrl_DIV = 1'b0; if8.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (if32.data_result !== 32'h0 || if32.data_exception !== 1'b0 || if32.data_resultRDY !== 1'b0 ||
        if32.tag_out !== 5'd0 || if32.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32: got %h/%b/%b/%0d/%b want all zero", if32.data_result,
               if32.data_exception, if32.data_resultRDY, if32.tag_out, if32.busy);
    end
    n_checks++;
    if (if8.data_result !== 8'h0 || if8.data_exception !== 1'b0 || if8.data_resultRDY !== 1'b0 ||
        if8.tag_out !== 3'd0 || if8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: got %h/%b/%b/%0d/%b want all zero", if8.data_result,
               if8.data_exception, if8.data_resultRDY, if8.tag_out, if8.busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    run32(1'b1, 1'b0, 32'd7,        32'hFFFF_FFFA, 5'd5,  32'hFFFF_FFD6, 1'b0, "mul_7x-6");
    run32(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0000_0000, 1'b1, "mul_ovf");
    run32(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 1'b0, "mul_-1x-1");
    run32(1'b1, 1'b0, 32'h8000_0000, 32'd1,        5'd8,  32'h8000_0000, 1'b0, "mul_minx1");
    run32(1'b1, 1'b1, 32'd6,        32'd3,         5'd11, 32'd18,        1'b0, "both_high");
  endtask

  task automatic test_divide();
    run32(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,        5'd1,  32'hFFFF_FFF2, 1'b0, "div_-100/7");
    run32(1'b0, 1'b1, 32'd5,        32'd0,         5'd2,  32'h0000_0000, 1'b1, "div_by0");
    run32(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1'b1, "div_min/-1");
    run32(1'b0, 1'b1, 32'd100,      32'hFFFF_FFF9, 5'd4,  32'hFFFF_FFF2, 1'b0, "div_100/-7");
  endtask

  task automatic test_restart();
    if32.data_operandA = 32'd3; if32.data_operandB = 32'd4; if32.tag_in = 5'd4;
    if32.ctrl_MULT = 1'b1;
    @(posedge clk); #1;
    if32.ctrl_MULT = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if32.ctrl_DIV = 1'b0;
      n_checks++;
      if (if32.data_resultRDY !== (n == 43) || if32.busy !== (n < 43)) begin
        n_fail++;
        $display("FAIL restart rdy/busy edge %0d: got %b/%b want %b/%b", n,
                 if32.data_resultRDY, if32.busy, (n == 43), (n < 43));
      end
      if (n == 43) begin
        n_checks++;
        if (if32.data_result !== 32'd5 || if32.data_exception !== 1'b0 || if32.tag_out !== 5'd9) begin
          n_fail++;
          $display("FAIL restart result: got %h/%b/%0d want 00000005/0/9", if32.data_result,
                   if32.data_exception, if32.tag_out);
        end
      end
      if (n == 9) begin
        if32.data_operandA = 32'd20; if32.data_operandB = 32'd4; if32.tag_in = 5'd9;
        if32.ctrl_DIV = 1'b1;
      end
    end
  endtask

  task automatic test_flush_reset();
    if32.data_operandA = 32'd20; if32.data_operandB = 32'd4; if32.tag_in = 5'd3;
    if32.ctrl_DIV = 1'b1;
    @(posedge clk); #1;
    if32.ctrl_DIV = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if32.flush = 1'b0;
      n_checks++;
      if (if32.data_resultRDY !== 1'b0 || if32.busy !== (n < 12)) begin
        n_fail++;
        $display("FAIL flush rdy/busy edge %0d: got %b/%b want 0/%b", n,
                 if32.data_resultRDY, if32.busy, (n < 12));
      end
      if (n == 11) if32.flush = 1'b1;
    end
    n_checks++;
    if (if32.data_result !== 32'd5 || if32.data_exception !== 1'b0 || if32.tag_out !== 5'd9) begin
      n_fail++;
      $display("FAIL flush hold: got %h/%b/%0d want 00000005/0/9", if32.data_result,
               if32.data_exception, if32.tag_out);
    end
    // Second operation, reset asserted mid-flight.
    if32.data_operandA = 32'd3; if32.data_operandB = 32'd4; if32.tag_in = 5'd2;
    if32.ctrl_MULT = 1'b1;
    @(posedge clk); #1;
    if32.ctrl_MULT = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if32.data_result !== 32'h0 || if32.data_exception !== 1'b0 || if32.data_resultRDY !== 1'b0 ||
        if32.tag_out !== 5'd0 || if32.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got %h/%b/%b/%0d/%b want all zero", if32.data_result,
               if32.data_exception, if32.data_resultRDY, if32.tag_out, if32.busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (if32.data_resultRDY !== 1'b0 || if32.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset rdy/busy cycle %0d: got %b/%b want 0/0", n,
                 if32.data_resultRDY, if32.busy);
      end
    end
  endtask

  task automatic test_width8();
    run8(1'b1, 8'h80, 8'h01, 3'd1, 8'h80, 1'b0, "w8_-128x1");
    run8(1'b1, 8'h10, 8'h08, 3'd2, 8'h80, 1'b1, "w8_16x8");
    run8(1'b0, 8'hF9, 8'h02, 3'd3, 8'hFD, 1'b0, "w8_-7/2");
    run8(1'b0, 8'h80, 8'hFF, 3'd4, 8'h80, 1'b1, "w8_min/-1");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_multiply();
    test_divide();
    test_restart();
    test_width8();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multdiv_iter.md
Name: multdiv_iter

Overview:
Parametrised iterative signed multiply/divide unit for the pipelined core's execute stage.
- Accepts a one-cycle start pulse with operands and a destination tag.
- Computes over a fixed number of cycles and returns result, exception flag and tag with a one-cycle ready pulse.
- Execute-stage control uses `busy` to stall younger instructions and `flush` to cancel on jumps.
- Generalises the fixed 32-bit multdiv to any WIDTH and adds tag tracking, restart-on-start and flush.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- TAG_W, 5, width of the destination-register tag carried with the operation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_operandA  in  WIDTH  signed multiplicand / dividend.
- data_operandB  in  WIDTH  signed multiplier / divisor.
- ctrl_MULT  in  1  start-multiply pulse; operands sampled on the same edge.
- ctrl_DIV  in  1  start-divide pulse; operands sampled on the same edge.
- tag_in  in  TAG_W  destination tag, sampled with start.
- flush  in  1  cancel the in-flight operation.
- data_result  out  WIDTH  signed result.
- data_exception  out  1  overflow or divide-by-zero, valid with ready.
- data_resultRDY  out  1  one-cycle result-valid pulse.
- tag_out  out  TAG_W  tag of the completed operation.
- busy  out  1  operation in flight.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. data_result=0, data_exception=0, data_resultRDY=0, tag_out=0, busy=0, counter=0.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - On a rising edge with ctrl_MULT=1 → MULT; with ctrl_DIV=1 and ctrl_MULT=0 → DIV.
  - Both high: MULT wins.
  - Start is honoured in every state, including MULT/DIV/DONE. It aborts the current operation with no ready pulse for it, captures the new operands/tag and resets the counter to 0.
- Latency L = WIDTH+1 edges. If start is sampled at edge k:
  - busy=1 from edge k to edge k+L.
  - MULT/DIV perform one iteration per edge for WIDTH edges, then enter DONE at edge k+L.
  - data_resultRDY=1 only between edge k+L and k+L+1.
  - DONE returns to IDLE on the next edge unless a new start is sampled.
- Outputs: data_result, data_exception and tag_out update at edge k+L. They hold until the next completion or reset.
- Multiply:
  - Radix-2 signed shift-add (Booth or sign-corrected), 2*WIDTH-bit internal product.
  - data_result = low WIDTH bits.
  - data_exception = 1 iff the high WIDTH+1 product bits are not all equal, i.e. the signed result does not fit.
- Divide:
  - Restoring or non-restoring on operand magnitudes; quotient sign = signA XOR signB.
  - Truncates toward zero; remainder discarded.
  - B=0: data_result=0, data_exception=1, same latency L.
  - A=MIN (1 followed by WIDTH-1 zeros) and B=-1: data_result=MIN, data_exception=1.
  - Otherwise data_exception=0.
- Flush:
  - flush=1 at an edge with no start: state→IDLE, busy=0, no ready pulse. Outputs hold prior values.
  - flush and start on the same edge: the start wins and flush is ignored.
  - flush in IDLE/DONE: DONE still pulses ready in its cycle; state→IDLE.
- Counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.
- Operand inputs are don't-care after the start edge.
- Reset asserted mid-operation: immediate return to reset values; no ready pulse after release.

Test Plan:
1. WIDTH=32: A=7, B=-6, ctrl_MULT pulse at edge 0, tag=5 → data_resultRDY=1 only after edge 33. result=0xFFFFFFD6 (-42), exception=0, tag_out=5; busy=1 edges 0–33.
2. Multiply A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. Multiply A=0xFFFFFFFF, B=0xFFFFFFFF → result=1, exception=0.
3. Divide -100/7 → result=0xFFFFFFF2 (-14), exception=0. 5/0 → result=0, exception=1 at edge 33. 0x80000000/-1 → result=0x80000000, exception=1.
4. Start multiply 3*4 at edge 0, start divide 20/4 at edge 10 with tag=9 → no pulse at edge 33. Single pulse after edge 43: result=5, tag_out=9.
5. Divide 20/4 at edge 0, flush at edge 12 → busy=0 after edge 12, no ready pulse through edge 50, outputs hold. Reset=0 at edge 20 of a second operation → all outputs 0 immediately; no pulse after release.
6. WIDTH=8, TAG_W=3: -128*1 → result=0x80, exception=0, ready after edge 9. 16*8 → result=0x80, exception=1. -7/2 → result=0xFD (-3).
